// File: rtl/div_unit_pkg.sv
// Shared divider constants: FSM state codes plus the ready/start encodings EX reuses for its stall request.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam logic [4:0] DivLastStep = 5'd31;

endpackage

// File: rtl/div_unit.sv
// 32-bit radix-2 restoring divider for DIV/DIVU, result {remainder, quotient}; ready 33 edges after start.
// Optional DIV_ZERO_FAST_EN: a zero divisor short-cuts through ZERO and returns 64'h0 after 2 edges.
module div_unit
   import div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   div_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] wr_q, wr_d;
   logic [31:0] divisor_q, divisor_d;
   logic        s1_q, s1_d;
   logic        s2_q, s2_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic [31:0] a_mag, b_mag;
   logic [32:0] rem_sh, diff;
   logic [31:0] rem_fix, quo_fix;

   always_comb begin
      a_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
      b_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

      // The 33rd remainder bit only exists between the shift and the subtract.
      rem_sh = {wr_q[63:32], wr_q[31]};
      diff   = rem_sh - {1'b0, divisor_q};

      rem_fix = s1_q ? (~wr_q[63:32] + 32'd1) : wr_q[63:32];
      quo_fix = (s1_q ^ s2_q) ? (~wr_q[31:0] + 32'd1) : wr_q[31:0];

      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      divisor_d = divisor_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      result_d  = result_q;
      ready_d   = ready_q;

      case (state_q)
         DivFree: begin
            ready_d  = DivResultNotReady;
            result_d = 64'd0;
            if (start_i == DivStart && !annul_i) begin
               s1_d      = signed_div_i & opdata1_i[31];
               s2_d      = signed_div_i & opdata2_i[31];
               divisor_d = b_mag;
               wr_d      = {32'd0, a_mag};
               cnt_d     = 5'd0;
`ifdef DIV_ZERO_FAST_EN
               state_d   = (opdata2_i == 32'd0) ? DivByZero : DivOn;
`else
               state_d   = DivOn;
`endif
            end
         end
`ifdef DIV_ZERO_FAST_EN
         DivByZero: begin
            wr_d    = 64'd0;
            s1_d    = 1'b0;
            s2_d    = 1'b0;
            state_d = DivEnd;
         end
`endif
         DivOn: begin
            if (diff[32]) begin
               wr_d = {rem_sh[31:0], wr_q[30:0], 1'b0};
            end else begin
               wr_d = {diff[31:0], wr_q[30:0], 1'b1};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == DivLastStep) begin
               state_d = DivEnd;
            end
         end
         DivEnd: begin
            // First END cycle publishes the sign-fixed result; afterwards hold until EX drops start.
            if (ready_q == DivResultNotReady) begin
               result_d = {rem_fix, quo_fix};
               ready_d  = DivResultReady;
            end else if (start_i == DivStop) begin
               state_d  = DivFree;
               ready_d  = DivResultNotReady;
               result_d = 64'd0;
            end
         end
         default: begin
            state_d = DivFree;
         end
      endcase

      if (annul_i && state_q != DivFree) begin
         state_d  = DivFree;
         ready_d  = DivResultNotReady;
         result_d = 64'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= 5'd0;
         wr_q      <= 64'd0;
         divisor_q <= 32'd0;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         result_q  <= 64'd0;
         ready_q   <= DivResultNotReady;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         divisor_q <= divisor_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit against an arithmetic reference; honours DIV_ZERO_FAST_EN when defined.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_checks = 0;
   int n_fail   = 0;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return 64'd0;
`endif
      if (!sgn) begin
         if (b == 32'd0) return {a, 32'hFFFF_FFFF};
         uq = a / b;
         ur = a % b;
         return {ur, uq};
      end
      if (b == 32'd0) begin
         // Magnitude quotient is all ones, negated when the dividend is negative; remainder regains a's sign.
         return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
      end
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return 2;
`endif
      return 33;
   endfunction

   task automatic run_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
      int lat;
      logic [63:0] exp;
      exp          = ref_div(sgn, a, b);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      tick();
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
      lat = 0;
      while (!ready_o && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(ref_lat(b)));
      check({tag, " result"}, result_o, exp);
      tick();
      check({tag, " hold"}, {63'd0, ready_o} ^ result_o, {63'd0, 1'b1} ^ exp);
      start_i = 1'b0;
      tick();
      check({tag, " drop ready"}, {63'd0, ready_o}, 64'd0);
      check({tag, " drop result"}, result_o, 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      bit          sgn;
      bit          rose;

      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (3) tick();
      check("reset ready", {63'd0, ready_o}, 64'd0);
      check("reset result", result_o, 64'd0);
      rst = 1'b0;
      tick();

      run_div("divu 100/7", 1'b0, 32'd100, 32'd7);
      run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      run_div("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_div("divu 0x1234/0", 1'b0, 32'h0000_1234, 32'd0);
      run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0);

      // Flush during ON: no result must appear.
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      tick();
      repeat (10) tick();
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      check("annul ready", {63'd0, ready_o}, 64'd0);
      check("annul result", result_o, 64'd0);
      rose = 1'b0;
      repeat (40) begin
         tick();
         if (ready_o) rose = 1'b1;
      end
      check("annul no ready", {63'd0, rose}, 64'd0);
      run_div("divu 9/3", 1'b0, 32'd9, 32'd3);

      // annul wins over start in IDLE; a later start must still take the full latency.
      annul_i = 1'b1;
      start_i = 1'b1;
      repeat (5) tick();
      check("annul idle ready", {63'd0, ready_o}, 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      tick();
      run_div("after idle annul", 1'b1, 32'd77, 32'hFFFF_FFF6);

      // Reset in the middle of ON.
      signed_div_i = 1'b1;
      opdata1_i    = 32'd12345;
      opdata2_i    = 32'd17;
      start_i      = 1'b1;
      tick();
      repeat (15) tick();
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      start_i = 1'b0;
      check("midreset ready", {63'd0, ready_o}, 64'd0);
      check("midreset result", result_o, 64'd0);
      tick();
      run_div("after reset", 1'b0, 32'hDEAD_BEEF, 32'd1);

      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 9))
            0:       b = 32'd0;
            1:       b = 32'd1;
            2:       b = 32'hFFFF_FFFF;
            3:       b = 32'($urandom_range(1, 15));
            4:       b = a;
            default: b = $urandom;
         endcase
         run_div($sformatf("rand%0d %0s %h/%h", i, sgn ? "div" : "divu", a, b), sgn, a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
